// File: rtl/zip_add_arbiter_if.sv
// Bundled request, shared-adder and response streams for zip_add_arbiter.
// master is the arbiter side; slave is the requester/adder environment side.
interface zip_add_arbiter_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_valid;
  logic           add_ready;
  logic [W-1:0]   add_res;
  logic           add_res_valid;
  logic           add_res_ready;
  logic [W-1:0]   rsp;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [CW-1:0]  outstanding;
  logic           err;

  modport master (
    input  req_a, req_b, req_valid, add_ready, add_res, add_res_valid, rsp_ready,
    output req_ready, add_a, add_b, add_valid, add_res_ready, rsp, rsp_valid,
           outstanding, err
  );

  modport slave (
    output req_a, req_b, req_valid, add_ready, add_res, add_res_valid, rsp_ready,
    input  req_ready, add_a, add_b, add_valid, add_res_ready, rsp, rsp_valid,
           outstanding, err
  );
endinterface

// File: rtl/zip_add_arbiter.sv
// Round-robin sharing of one in-order stream adder between N requesters; an
// in-order tag FIFO steers each adder result back to the requester that issued it.
module zip_add_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  zip_add_arbiter_if.master bus
);
  localparam int PW = $clog2(N);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Every stream here transfers on a cycle where valid && ready are both high
  // at the rising edge; valid never waits for ready, and ready may depend on valid.

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant;
  logic          found;
  logic          can_issue;
  logic          accept;
  logic          pop;
  logic          nonempty;
  logic          res_ready;
  logic [PW-1:0] head;
  logic [PW-1:0] tags [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          valid_q;
  logic          err_q;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N) j = j - N;
    return PW'(j);
  endfunction

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req_valid[rr_idx(ptr, k)]) begin
        grant = rr_idx(ptr, k);
        found = 1'b1;
      end
    end
  end

  // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
  assign can_issue = !rst && (!valid_q || bus.add_ready) && (count < CW'(DEPTH));
  assign accept    = can_issue && found;
  assign nonempty  = (count != '0);
  assign head      = tags[rd_ptr];
  assign res_ready = nonempty && bus.rsp_ready[head] && !rst;
  assign pop       = bus.add_res_valid && res_ready;

  assign bus.req_ready     = accept ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
  assign bus.add_a         = a_q;
  assign bus.add_b         = b_q;
  assign bus.add_valid     = valid_q;
  assign bus.add_res_ready = res_ready;
  assign bus.rsp           = bus.add_res;
  assign bus.rsp_valid     = (bus.add_res_valid && nonempty) ?
                             ({{(N-1){1'b0}}, 1'b1} << head) : '0;
  assign bus.outstanding   = count;
  assign bus.err           = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.req_a[grant*W +: W];
        b_q     <= bus.req_b[grant*W +: W];
        valid_q <= 1'b1;
        wr_ptr  <= wr_ptr + 1'b1;
        ptr     <= (grant == PW'(N - 1)) ? '0 : grant + 1'b1;
      end else if (bus.add_ready) begin
        valid_q <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop) count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      // A result with no owner is left unconsumed and latched as a protocol error.
      if (bus.add_res_valid && !nonempty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tags[wr_ptr] <= grant;
  end
endmodule

// File: tb/tb_zip_add_arbiter.sv
// Directed bench for zip_add_arbiter: queue-level reference model checked every
// cycle, a 2-cycle in-order adder model, and literal pins per scenario.
module tb_zip_add_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zip_add_arbiter_if #(.N(N), .W(W), .DEPTH(DEPTH)) bus ();
  zip_add_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- stimulus shadows ----------------
  logic         s_rst;
  logic [N-1:0] s_valid;
  logic [W-1:0] s_a [N];
  logic [W-1:0] s_b [N];
  logic [N-1:0] s_rsp_ready;
  logic         s_add_ready;
  logic         s_stall;
  logic         s_inject;
  logic [W-1:0] s_inj_val;
  logic         inj_on;

  // adder environment: results with the cycle they become available
  logic [W-1:0] aq_res [$];
  int           aq_rdy [$];

  // reference model
  int           m_ptr;
  int           mq [$];
  logic [W-1:0] exp_q [$];
  logic         m_valid;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_err;

  // observation logs
  int           acc_tag [$];
  int           acc_cyc [$];
  int           pop_cyc [$];
  logic [W-1:0] rsp_log [$];
  logic [N-1:0] rsp_vec [$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    rst = s_rst;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = s_a[i];
      bus.req_b[i*W +: W] = s_b[i];
    end
    bus.req_valid = s_valid;
    bus.rsp_ready = s_rsp_ready;
    bus.add_ready = s_add_ready;
    inj_on        = s_inject;
    if (s_inject) begin
      bus.add_res_valid = 1'b1;
      bus.add_res       = s_inj_val;
    end else if (!s_stall && aq_res.size() > 0 && aq_rdy[0] <= cyc) begin
      bus.add_res_valid = 1'b1;
      bus.add_res       = aq_res[0];
    end else begin
      bus.add_res_valid = 1'b0;
      bus.add_res       = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic clear_logs();
    acc_tag.delete();
    acc_cyc.delete();
    pop_cyc.delete();
    rsp_log.delete();
    rsp_vec.delete();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((bus.outstanding != 0 || exp_q.size() != 0) && t < 40) begin
      tick();
      t++;
    end
    check("drain_outstanding", 32'(bus.outstanding), 32'd0);
    check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- compare process + model ----------------
  int           e_g;
  logic         e_found;
  logic         e_can;
  logic [N-1:0] e_rdy;
  logic [N-1:0] e_rv;
  logic         e_arr;
  int           e_sz;

  always @(negedge clk) begin
    e_sz  = mq.size();
    e_can = !rst && (!m_valid || bus.add_ready) && (e_sz < DEPTH);
    e_found = 1'b0;
    e_g = 0;
    for (int k = 0; k < N; k++) begin
      if (!e_found && bus.req_valid[(m_ptr + k) % N]) begin
        e_found = 1'b1;
        e_g = (m_ptr + k) % N;
      end
    end
    e_rdy = '0;
    if (e_can && e_found) e_rdy[e_g] = 1'b1;
    e_rv = '0;
    if (bus.add_res_valid && e_sz > 0) e_rv[mq[0]] = 1'b1;
    e_arr = (e_sz > 0) && !rst && bus.rsp_ready[(e_sz > 0) ? mq[0] : 0];

    check("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    check("add_valid", 32'(bus.add_valid), 32'(m_valid));
    check("add_a", 32'(bus.add_a), 32'(m_a));
    check("add_b", 32'(bus.add_b), 32'(m_b));
    check("outstanding", 32'(bus.outstanding), 32'(e_sz));
    check("err", 32'(bus.err), 32'(m_err));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    check("add_res_ready", 32'(bus.add_res_ready), 32'(e_arr));
    if (e_rv != '0) check("rsp_passthru", 32'(bus.rsp), 32'(bus.add_res));

    // logs of what the DUT actually did
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        acc_tag.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    if (bus.add_res_valid && bus.add_res_ready) begin
      rsp_log.push_back(bus.rsp);
      rsp_vec.push_back(bus.rsp_valid);
      pop_cyc.push_back(cyc);
    end

    // adder environment reacts to the DUT's handshakes
    if (bus.add_valid && bus.add_ready) begin
      aq_res.push_back(W'(bus.add_a + bus.add_b));
      aq_rdy.push_back(cyc + 2);
    end
    if (bus.add_res_valid && bus.add_res_ready && !inj_on && aq_res.size() > 0) begin
      void'(aq_res.pop_front());
      void'(aq_rdy.pop_front());
    end

    // model state advance for the coming edge
    if (rst) begin
      m_ptr = 0;
      mq.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_a = '0;
      m_b = '0;
      m_err = 1'b0;
      aq_res.delete();
      aq_rdy.delete();
    end else begin
      if (bus.add_res_valid && e_arr) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
        else begin
          check("rsp_data", 32'(bus.rsp), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        void'(mq.pop_front());
      end
      if (e_can && e_found) begin
        m_a = bus.req_a[e_g*W +: W];
        m_b = bus.req_b[e_g*W +: W];
        m_valid = 1'b1;
        m_ptr = (e_g + 1) % N;
        mq.push_back(e_g);
        exp_q.push_back(W'(m_a + m_b));
      end else if (m_valid && bus.add_ready) begin
        m_valid = 1'b0;
      end
      if (bus.add_res_valid && e_sz == 0) m_err = 1'b1;
    end
    cyc++;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    m_ptr = 0; m_valid = 1'b0; m_a = '0; m_b = '0; m_err = 1'b0;
    s_rst = 1'b1; s_valid = '1; s_rsp_ready = '1; s_add_ready = 1'b1;
    s_stall = 1'b0; s_inject = 1'b0; s_inj_val = '0;
    for (int i = 0; i < N; i++) begin
      s_a[i] = W'(i);
      s_b[i] = 8'd10;
    end
    drive();

    // reset with all requesters asserting valid
    for (int r = 0; r < 3; r++) begin
      tick();
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_add_valid", 32'(bus.add_valid), 32'd0);
      check("rst_outstanding", 32'(bus.outstanding), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
    end

    // round robin, a=i b=10
    clear_logs();
    s_rst = 1'b0;
    for (int r = 0; r < 8; r++) tick();
    s_valid = '0;
    drain();
    check("rr_first_grant", 32'(acc_tag[0]), 32'd0);
    check("rr_accept_count_ge5", 32'(acc_tag.size() >= 5), 32'd1);
    for (int i = 0; i < acc_tag.size(); i++) check("rr_order", 32'(acc_tag[i]), 32'(i % 4));
    if (rsp_log.size() < 4) check("rr_rsp_count", 32'(rsp_log.size()), 32'd4);
    else begin
      check("rr_rsp0", 32'(rsp_log[0]), 32'd10);
      check("rr_rsp1", 32'(rsp_log[1]), 32'd11);
      check("rr_rsp2", 32'(rsp_log[2]), 32'd12);
      check("rr_rsp3", 32'(rsp_log[3]), 32'd13);
      check("rr_vec0", 32'(rsp_vec[0]), 32'h1);
      check("rr_vec1", 32'(rsp_vec[1]), 32'h2);
      check("rr_vec2", 32'(rsp_vec[2]), 32'h4);
      check("rr_vec3", 32'(rsp_vec[3]), 32'h8);
    end

    // single source, sum wraps to 44
    clear_logs();
    s_valid = 4'b0100; s_a[2] = 8'd200; s_b[2] = 8'd100;
    for (int r = 0; r < 4; r++) tick();
    s_valid = '0;
    drain();
    if (acc_cyc.size() < 3) check("single_accepts", 32'(acc_cyc.size()), 32'd3);
    else begin
      check("single_b2b_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
      check("single_b2b_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
    end
    check("single_rsp", 32'(rsp_log[0]), 32'd44);
    check("single_vec", 32'(rsp_vec[0]), 32'h4);

    // adder backpressure holds the issue register and blocks accepts
    clear_logs();
    s_valid = 4'b0001; s_a[0] = 8'd5; s_b[0] = 8'd6; s_add_ready = 1'b0;
    for (int r = 0; r < 3; r++) tick();
    check("bpa_outstanding", 32'(bus.outstanding), 32'd1);
    check("bpa_add_valid", 32'(bus.add_valid), 32'd1);
    check("bpa_req_ready", 32'(bus.req_ready), 32'd0);
    check("bpa_add_a", 32'(bus.add_a), 32'd5);
    s_add_ready = 1'b1; s_valid = '0;
    drain();
    check("bpa_rsp", 32'(rsp_log[0]), 32'd11);

    // full: results stalled, requester 1 streaming
    clear_logs();
    s_stall = 1'b1; s_valid = 4'b0010; s_a[1] = 8'd7; s_b[1] = 8'd1;
    for (int r = 0; r < 8; r++) tick();
    check("full_accepts", 32'(acc_tag.size()), 32'd4);
    check("full_outstanding", 32'(bus.outstanding), 32'd4);
    check("full_req_ready", 32'(bus.req_ready), 32'd0);
    s_stall = 1'b0;
    tick();
    s_stall = 1'b1;
    tick();
    check("full_reopen_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check("full_accepts_after", 32'(acc_tag.size()), 32'd5);
    check("full_pops", 32'(pop_cyc.size()), 32'd1);
    if (acc_cyc.size() == 5 && pop_cyc.size() == 1)
      check("full_accept_after_pop", 32'(acc_cyc[4] - pop_cyc[0]), 32'd1);
    s_valid = '0; s_stall = 1'b0;
    tick();
    drain();

    // response backpressure on requester 3
    clear_logs();
    s_valid = 4'b1000; s_a[3] = 8'd3; s_b[3] = 8'd10; s_rsp_ready = 4'b0111;
    tick();
    s_valid = '0;
    tick();
    begin
      int t;
      t = 0;
      while (!bus.add_res_valid && t < 10) begin
        tick();
        t++;
      end
    end
    check("bp_arrive", 32'(bus.add_res_valid), 32'd1);
    for (int r = 0; r < 5; r++) begin
      check("bp_add_res_ready", 32'(bus.add_res_ready), 32'd0);
      check("bp_rsp_hold", 32'(bus.rsp), 32'd13);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h8);
      check("bp_outstanding", 32'(bus.outstanding), 32'd1);
      if (r < 4) tick();
    end
    s_rsp_ready = '1;
    tick();
    check("bp_release_ready", 32'(bus.add_res_ready), 32'd1);
    check("bp_release_out", 32'(bus.outstanding), 32'd1);
    tick();
    check("bp_after_out", 32'(bus.outstanding), 32'd0);
    check("bp_pops", 32'(pop_cyc.size()), 32'd1);

    // protocol error: result with nothing outstanding
    s_inject = 1'b1; s_inj_val = 8'h55;
    tick();
    check("perr_res_ready", 32'(bus.add_res_ready), 32'd0);
    check("perr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("perr_err_before", 32'(bus.err), 32'd0);
    s_inject = 1'b0;
    tick();
    check("perr_err_set", 32'(bus.err), 32'd1);
    tick();
    tick();
    check("perr_err_sticky", 32'(bus.err), 32'd1);
    s_rst = 1'b1;
    tick();
    tick();
    check("perr_err_cleared", 32'(bus.err), 32'd0);
    s_rst = 1'b0;
    tick();
    check("perr_post_err", 32'(bus.err), 32'd0);
    check("perr_post_out", 32'(bus.outstanding), 32'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
